qs_mc: RTL

- Parametrised multi-channel queue selector between IBM (metadata in) and MB (queue writers out).
- Classifies each 24-bit metadata word by traffic class: TSN words go to one of SLOT_NUM time-slot channels, selected by the current slot index from LCM; RC/PTP words go to the shaped channel; BE words go to the best-effort channel.
- Adds a per-channel elastic FIFO with downstream ready backpressure, saturating RC length arithmetic, and drop accounting.

---
 rtl/qs_pkg.sv | 36 +++
 rtl/qs_ch_fifo.sv | 58 +++++
 rtl/qs_mc.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/qs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qs_pkg
// Description : Shared class codes, metadata field positions and channel
//               index helpers for the qs_mc queue selector.
// Revision    : 1.0 - initial release
// ============================================================================
package qs_pkg;

    typedef enum logic [2:0] {
        QS_CLS_BE  = 3'd0,
        QS_CLS_RC  = 3'd1,
        QS_CLS_PTP = 3'd2,
        QS_CLS_TSN = 3'd3
    } qs_cls_e;

    localparam int c_MD_W       = 24;
    localparam int c_CLS_HI     = 23;
    localparam int c_CLS_LO     = 21;
    localparam int c_TS_BASE_CH = 0;

    // Channel map: TSN slots occupy 0..SLOT_NUM-1, then RC, then BE.
    function automatic int qs_rc_ch(input int slot_num);
        return slot_num;
    endfunction

    function automatic int qs_be_ch(input int slot_num);
        return slot_num + 1;
    endfunction

    function automatic int qs_ch_w(input int slot_num);
        return $clog2(slot_num + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/qs_ch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : qs_ch_fifo
// Description : Per-channel synchronous FIFO; caller never pushes when full
//               without popping, nor pops when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module qs_ch_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (c_AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/qs_mc.sv
`default_nettype none
// ============================================================================
// Module      : qs_mc
// Description : Multi-channel queue selector: classifies metadata into TSN
//               slot, shaped (RC/PTP) and best-effort channel FIFOs.
//               Define QS_DROP_CNT_EN to build the drop / bad-class counters.
// Revision    : 1.0 - initial release
// ============================================================================
module qs_mc
    import qs_pkg::*;
#(
    parameter int SLOT_NUM   = 2,
    parameter int SLOT_W     = (SLOT_NUM > 1 ? $clog2(SLOT_NUM) : 1),
    parameter int PTR_W      = 9,
    parameter int LEN_W      = 12,
    parameter int META_OVH   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SLOT_W-1:0]         in_qs_time_slot,
    input  logic [23:0]               in_qs_md,
    input  logic                      in_qs_md_wr,
    output logic [SLOT_NUM*PTR_W-1:0] out_qs_ts_md,
    output logic [SLOT_NUM-1:0]       out_qs_ts_md_wr,
    input  logic [SLOT_NUM-1:0]       in_qs_ts_rdy,
    output logic [LEN_W+PTR_W-1:0]    out_qs_rc_md,
    output logic                      out_qs_rc_md_wr,
    input  logic                      in_qs_rc_rdy,
    output logic [PTR_W-1:0]          out_qs_be_md,
    output logic                      out_qs_be_md_wr,
    input  logic                      in_qs_be_rdy,
    output logic [CNT_W-1:0]          out_qs_drop_cnt,
    output logic [CNT_W-1:0]          out_qs_bad_cls_cnt
);

    localparam int c_CH_W   = qs_ch_w(SLOT_NUM);
    localparam int c_NUM_CH = SLOT_NUM + 2;
    localparam int c_RC_CH  = qs_rc_ch(SLOT_NUM);
    localparam int c_BE_CH  = qs_be_ch(SLOT_NUM);
    localparam int c_RC_W   = LEN_W + PTR_W;
    localparam int c_CNT_AW = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]          w_cls;
    logic [LEN_W-1:0]    w_len;
    logic [PTR_W-1:0]    w_ptr;
    logic [LEN_W-1:0]    w_token;
    logic [c_CH_W-1:0]   w_ts_ch;

    logic                r_dec_vld;
    logic [c_CH_W-1:0]   r_dec_ch;
    logic [c_RC_W-1:0]   r_dec_data;

    logic [c_NUM_CH-1:0] w_rdy;
    logic [c_NUM_CH-1:0] w_full;
    logic [c_NUM_CH-1:0] w_empty;
    logic [c_NUM_CH-1:0] w_pop;
    logic [c_NUM_CH-1:0] w_push_req;
    logic [c_NUM_CH-1:0] w_push_ok;

    assign w_cls = in_qs_md[c_CLS_HI:c_CLS_LO];
    assign w_len = in_qs_md[PTR_W+LEN_W-1:PTR_W];
    assign w_ptr = in_qs_md[PTR_W-1:0];

    // Length minus overhead, clamped at zero so short packets never wrap.
    assign w_token = (w_len > LEN_W'(META_OVH)) ? (w_len - LEN_W'(META_OVH)) : '0;

    generate
        if (SLOT_NUM > 1) begin : g_slot_sel
            assign w_ts_ch = c_CH_W'(c_TS_BASE_CH) + c_CH_W'(in_qs_time_slot);
        end else begin : g_slot_fix
            assign w_ts_ch = c_CH_W'(c_TS_BASE_CH);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_vld  <= 1'b0;
            r_dec_ch   <= '0;
            r_dec_data <= '0;
        end else begin
            r_dec_vld  <= 1'b0;
            r_dec_ch   <= '0;
            r_dec_data <= '0;
            if (in_qs_md_wr) begin
                case (w_cls)
                    QS_CLS_TSN: begin
                        r_dec_vld  <= 1'b1;
                        r_dec_ch   <= w_ts_ch;
                        r_dec_data <= {{LEN_W{1'b0}}, w_ptr};
                    end
                    QS_CLS_PTP: begin
                        r_dec_vld  <= 1'b1;
                        r_dec_ch   <= c_CH_W'(c_RC_CH);
                        r_dec_data <= {{LEN_W{1'b0}}, w_ptr};
                    end
                    QS_CLS_RC: begin
                        r_dec_vld  <= 1'b1;
                        r_dec_ch   <= c_CH_W'(c_RC_CH);
                        r_dec_data <= {w_token, w_ptr};
                    end
                    QS_CLS_BE: begin
                        r_dec_vld  <= 1'b1;
                        r_dec_ch   <= c_CH_W'(c_BE_CH);
                        r_dec_data <= {{LEN_W{1'b0}}, w_ptr};
                    end
                    default: r_dec_vld <= 1'b0;
                endcase
            end
        end
    end

    assign w_rdy = {in_qs_be_rdy, in_qs_rc_rdy, in_qs_ts_rdy};

    // A full FIFO still accepts when its head leaves in the same cycle.
    generate
        for (genvar k = 0; k < c_NUM_CH; k++) begin : g_ctl
            assign w_pop[k]      = !w_empty[k] && w_rdy[k];
            assign w_push_req[k] = r_dec_vld && (r_dec_ch == c_CH_W'(k));
            assign w_push_ok[k]  = w_push_req[k] && (!w_full[k] || w_pop[k]);
        end
    endgenerate

    generate
        for (genvar k = 0; k < SLOT_NUM; k++) begin : g_ts
            logic [PTR_W-1:0]    w_head;
            logic [c_CNT_AW-1:0] w_cnt_unused;
            logic                r_wr;
            logic [PTR_W-1:0]    r_md;

            qs_ch_fifo #(.WIDTH(PTR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_push  (w_push_ok[k]),
                .i_din   (r_dec_data[PTR_W-1:0]),
                .i_pop   (w_pop[k]),
                .o_dout  (w_head),
                .o_full  (w_full[k]),
                .o_empty (w_empty[k]),
                .o_count (w_cnt_unused)
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr <= 1'b0;
                    r_md <= '0;
                end else begin
                    r_wr <= w_pop[k];
                    r_md <= w_pop[k] ? w_head : '0;
                end
            end

            assign out_qs_ts_md[k*PTR_W +: PTR_W] = r_md;
            assign out_qs_ts_md_wr[k]             = r_wr;
        end
    endgenerate

    generate
        if (1) begin : g_rc
            logic [c_RC_W-1:0]   w_head;
            logic [c_CNT_AW-1:0] w_cnt_unused;
            logic                r_wr;
            logic [c_RC_W-1:0]   r_md;

            qs_ch_fifo #(.WIDTH(c_RC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_push  (w_push_ok[c_RC_CH]),
                .i_din   (r_dec_data),
                .i_pop   (w_pop[c_RC_CH]),
                .o_dout  (w_head),
                .o_full  (w_full[c_RC_CH]),
                .o_empty (w_empty[c_RC_CH]),
                .o_count (w_cnt_unused)
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr <= 1'b0;
                    r_md <= '0;
                end else begin
                    r_wr <= w_pop[c_RC_CH];
                    r_md <= w_pop[c_RC_CH] ? w_head : '0;
                end
            end

            assign out_qs_rc_md    = r_md;
            assign out_qs_rc_md_wr = r_wr;
        end
    endgenerate

    generate
        if (1) begin : g_be
            logic [PTR_W-1:0]    w_head;
            logic [c_CNT_AW-1:0] w_cnt_unused;
            logic                r_wr;
            logic [PTR_W-1:0]    r_md;

            qs_ch_fifo #(.WIDTH(PTR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_push  (w_push_ok[c_BE_CH]),
                .i_din   (r_dec_data[PTR_W-1:0]),
                .i_pop   (w_pop[c_BE_CH]),
                .o_dout  (w_head),
                .o_full  (w_full[c_BE_CH]),
                .o_empty (w_empty[c_BE_CH]),
                .o_count (w_cnt_unused)
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr <= 1'b0;
                    r_md <= '0;
                end else begin
                    r_wr <= w_pop[c_BE_CH];
                    r_md <= w_pop[c_BE_CH] ? w_head : '0;
                end
            end

            assign out_qs_be_md    = r_md;
            assign out_qs_be_md_wr = r_wr;
        end
    endgenerate

`ifdef QS_DROP_CNT_EN
    logic             w_drop;
    logic             r_dec_bad;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_bad_cls_cnt;

    assign w_drop = |(w_push_req & ~w_push_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_bad     <= 1'b0;
            r_drop_cnt    <= '0;
            r_bad_cls_cnt <= '0;
        end else begin
            r_dec_bad <= in_qs_md_wr && w_cls[2];
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            if (r_dec_bad && (r_bad_cls_cnt != {CNT_W{1'b1}})) begin
                r_bad_cls_cnt <= r_bad_cls_cnt + 1'b1;
            end
        end
    end

    assign out_qs_drop_cnt    = r_drop_cnt;
    assign out_qs_bad_cls_cnt = r_bad_cls_cnt;
`else
    assign out_qs_drop_cnt    = '0;
    assign out_qs_bad_cls_cnt = '0;
`endif

endmodule
`default_nettype wire
